// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmit controller: decodes a 16-byte MMIO window on the core data bus,
// queues TX bytes in a FIFO and hands them to the Uart one at a time via start/busy.
module uart_tx_ctrl #(
    parameter logic [31:0] UART_BASE  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic [3:0]  write_mask,
    input  logic [31:0] dmem_read_data,
    output logic [31:0] read_data,
    output logic        dmem_write_enable,
    output logic        uart_start,
    output logic [7:0]  uart_data,
    input  logic        uart_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          hit, full, empty;
    logic [1:0]    reg_sel;
    logic          push_req, push_ok, status_wr, pop;
    logic          start_d;
    logic [7:0]    data_d;
    logic [31:0]   status;
    logic          unused;

    assign unused  = ^{address[1:0], write_data[31:8], write_mask[3:1]};

    assign hit     = (address[31:4] == UART_BASE[31:4]);
    assign reg_sel = address[3:2];
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);

    assign push_req  = write_enable & hit & (reg_sel == 2'd0) & write_mask[0];
    assign push_ok   = push_req & ~full;
    assign status_wr = write_enable & hit & (reg_sel == 2'd1);

    always_comb begin
        status          = '0;
        status[0]       = full;
        status[1]       = empty;
        status[2]       = uart_busy;
        status[3]       = overflow;
        status[8 +: CW] = count;
    end

    always_comb begin
        if (!hit)                 read_data = dmem_read_data;
        else if (reg_sel == 2'd1) read_data = status;
        else                      read_data = '0;
    end

    assign dmem_write_enable = write_enable & ~hit;

    // Pop only on the IDLE->START transition; the head byte is latched into uart_data there.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        start_d = 1'b0;
        data_d  = uart_data;
        case (state_q)
            IDLE: begin
                if (!empty && !uart_busy) begin
                    pop     = 1'b1;
                    start_d = 1'b1;
                    data_d  = mem[rd_ptr];
                    state_d = START;
                end
            end
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (uart_busy)  state_d = WAIT_DONE;
            WAIT_DONE: if (!uart_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            uart_start <= 1'b0;
            uart_data  <= '0;
        end else begin
            state_q    <= state_d;
            uart_start <= start_d;
            uart_data  <= data_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= write_data[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && full) overflow <= 1'b1;
            else if (status_wr)   overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: a queue-based transmit model checked every cycle,
// plus hand-computed STATUS/latency/byte-order expectations.
module tb_uart_tx_ctrl;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 0, rst = 0;
    logic [31:0] address = 32'h200, write_data = 0, dmem_read_data = 0;
    logic        write_enable = 0;
    logic [3:0]  write_mask = 0;
    logic        hold_busy = 0;
    int          busy_left = 0;
    wire  [31:0] read_data;
    wire         dmem_write_enable, uart_start, uart_busy;
    wire  [7:0]  uart_data;

    assign uart_busy = hold_busy || (busy_left != 0);
    always #5 clk = ~clk;

    uart_tx_ctrl #(.UART_BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .write_enable(write_enable), .write_mask(write_mask),
        .dmem_read_data(dmem_read_data), .read_data(read_data),
        .dmem_write_enable(dmem_write_enable), .uart_start(uart_start),
        .uart_data(uart_data), .uart_busy(uart_busy)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queued bytes, sticky overflow, and one transmission slot that is
    // busy from a send until the Uart has shown busy and then dropped it.
    logic [7:0] q[$], sent[$], exp_sent[$];
    logic       m_ovf = 0, m_start = 0, in_flight = 0, gap = 0, saw_busy = 0;
    logic       was_full, can_pop;
    logic [7:0] m_data = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            q.delete();
            m_ovf = 0; m_start = 0; m_data = 0; in_flight = 0; gap = 0; saw_busy = 0;
        end else begin
            was_full = (q.size() == DEPTH);
            can_pop  = !in_flight && q.size() != 0 && !uart_busy;
            m_start  = 0;
            if (in_flight) begin
                if (gap)                        gap = 0;
                else if (!saw_busy)             saw_busy = uart_busy;
                else if (!uart_busy)            in_flight = 0;
            end
            if (can_pop) begin
                m_data = q.pop_front();
                sent.push_back(m_data);
                m_start = 1; in_flight = 1; gap = 1; saw_busy = 0;
            end
            if (write_enable && address[31:4] == BASE[31:4]) begin
                if (address[3:2] == 2'd0 && write_mask[0]) begin
                    if (was_full) m_ovf = 1;
                    else          q.push_back(write_data[7:0]);
                end else if (address[3:2] == 2'd1) m_ovf = 0;
            end
        end
    end

    function automatic logic [31:0] m_status();
        logic [31:0] s = 0;
        s[0]     = (q.size() == DEPTH);
        s[1]     = (q.size() == 0);
        s[2]     = uart_busy;
        s[3]     = m_ovf;
        s[11:8]  = 4'(q.size());
        return s;
    endfunction

    // Uart stand-in: busy for 10 cycles after each start pulse.
    initial forever begin
        @(negedge clk); #2;
        if (uart_start)         busy_left = 10;
        else if (busy_left > 0) busy_left--;
    end

    initial forever begin
        logic [31:0] exp_rd;
        logic        ehit;
        @(negedge clk);
        ehit = (address[31:4] == BASE[31:4]);
        if (!ehit)                   exp_rd = dmem_read_data;
        else if (address[3:2] == 1)  exp_rd = m_status();
        else                         exp_rd = 0;
        chk("read_data", read_data, exp_rd);
        chk("dmem_we", {31'd0, dmem_write_enable}, {31'd0, ehit ? 1'b0 : write_enable});
        chk("uart_start", {31'd0, uart_start}, {31'd0, m_start});
        chk("uart_data", {24'd0, uart_data}, {24'd0, m_data});
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        address = a; write_data = d; write_mask = m; write_enable = 1;
        @(posedge clk); #1;
        write_enable = 0; write_mask = 0; address = 32'h200;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (!(q.size() == 0 && !in_flight && !uart_busy) && n < max) begin
            @(posedge clk); #1; n++;
        end
        if (n >= max) begin
            checks++; errors++;
            $display("FAIL wait_idle: timeout after %0d cycles", max);
        end
    endtask

    task automatic wait_notfull(input int max);
        int n = 0;
        while (q.size() == DEPTH && n < max) begin
            @(posedge clk); #1; n++;
        end
        if (n >= max) begin
            checks++; errors++;
            $display("FAIL wait_notfull: timeout after %0d cycles", max);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 address = BASE + 4;
        #1 chk("reset_status", read_data, 32'h2);
        @(negedge clk); #1 rst = 1;
        @(posedge clk); #1;

        // mid-operation async reset with queued bytes
        hold_busy = 1;
        wr(BASE, 32'hF1, 4'h1); wr(BASE, 32'hF2, 4'h1); wr(BASE, 32'hF3, 4'h1);
        address = BASE + 4;
        @(negedge clk) chk("pre_reset_status", read_data, 32'h304);
        @(posedge clk); #1 hold_busy = 0; rst = 0;
        #1 chk("async_status", read_data, 32'h2);
        chk("async_start", {31'd0, uart_start}, 32'd0);
        chk("async_data", {24'd0, uart_data}, 32'd0);
        @(negedge clk); #1 rst = 1;
        @(posedge clk); #1;

        // single byte with latency
        wr(BASE, 32'h41, 4'h1); exp_sent.push_back(8'h41);
        @(negedge clk) chk("lat_n", {31'd0, uart_start}, 32'd0);
        @(negedge clk) chk("lat_n1", {31'd0, uart_start}, 32'd1);
        chk("byte_41", {24'd0, uart_data}, 32'h41);
        @(negedge clk) chk("lat_n2", {31'd0, uart_start}, 32'd0);
        @(posedge clk); #1;
        wait_idle(200);
        address = BASE + 4;
        @(negedge clk) chk("status_after_tx", read_data, 32'h2);
        @(posedge clk); #1;
        wr(BASE, 32'h77, 4'b1110);
        address = BASE + 4;
        @(negedge clk) chk("mask0_ignored", read_data, 32'h2);
        @(posedge clk); #1 address = BASE + 8;
        @(negedge clk) chk("reserved_rd", read_data, 32'h0);
        @(posedge clk); #1;

        // fill and overflow
        hold_busy = 1;
        for (int i = 1; i <= 9; i++) wr(BASE, i, 4'h1);
        for (int i = 1; i <= 8; i++) exp_sent.push_back(8'(i));
        address = BASE + 4;
        @(negedge clk) chk("full_status", read_data, 32'h80D);
        @(posedge clk); #1 hold_busy = 0;
        wait_idle(1000);
        address = BASE + 4;
        @(negedge clk) chk("drained_ovf", read_data, 32'hA);
        @(posedge clk); #1;

        // overflow clear keeps other bits
        hold_busy = 1;
        wr(BASE, 32'hA1, 4'h1); wr(BASE, 32'hA2, 4'h1);
        exp_sent.push_back(8'hA1); exp_sent.push_back(8'hA2);
        address = BASE + 4;
        @(negedge clk) chk("pre_clear", read_data, 32'h20C);
        @(posedge clk); #1;
        wr(BASE + 4, 32'hFFFF_FFFF, 4'hF);
        address = BASE + 4;
        @(negedge clk) chk("post_clear", read_data, 32'h204);
        @(posedge clk); #1 hold_busy = 0;
        wait_idle(500);

        // passthrough
        address = 32'h100; write_data = 32'hDEADBEEF; write_mask = 4'hF; write_enable = 1;
        dmem_read_data = 32'hCAFE_F00D;
        @(negedge clk) chk("pass_we", {31'd0, dmem_write_enable}, 32'd1);
        @(posedge clk); #1 write_enable = 0; write_mask = 0;
        @(negedge clk) chk("pass_load", read_data, 32'hCAFE_F00D);
        @(posedge clk); #1 address = BASE + 4;
        @(negedge clk) chk("pass_no_fifo", read_data, 32'h2);
        @(posedge clk); #1;
        address = BASE; write_data = 32'h5A; write_mask = 4'h1; write_enable = 1;
        exp_sent.push_back(8'h5A);
        @(negedge clk) chk("win_we_gated", {31'd0, dmem_write_enable}, 32'd0);
        @(posedge clk); #1 write_enable = 0; write_mask = 0; address = 32'h200;
        wait_idle(500);

        // push concurrent with pop at count=3, then wrap traffic
        hold_busy = 1;
        wr(BASE, 32'hB1, 4'h1); wr(BASE, 32'hB2, 4'h1); wr(BASE, 32'hB3, 4'h1);
        address = BASE; write_data = 32'hB4; write_mask = 4'h1; write_enable = 1; hold_busy = 0;
        @(posedge clk); #1 write_enable = 0; write_mask = 0; address = BASE + 4;
        @(negedge clk) chk("push_pop_cnt3", read_data, 32'h300);
        for (int i = 1; i <= 4; i++) exp_sent.push_back(8'hB0 + 8'(i));
        @(posedge clk); #1;
        wait_idle(500);
        for (int i = 0; i < 20; i++) begin
            wait_notfull(500);
            wr(BASE, 32'hC0 + i, 4'h1);
            exp_sent.push_back(8'hC0 + 8'(i));
        end
        wait_idle(2000);
        repeat (5) @(posedge clk);

        chk("sent_count", sent.size(), 36);
        chk("exp_count", exp_sent.size(), sent.size());
        for (int i = 0; i < exp_sent.size() && i < sent.size(); i++)
            chk($sformatf("order_%0d", i), {24'd0, sent[i]}, {24'd0, exp_sent[i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
